pe_idx_loader: RTL and testbench

//  Write-side front end of the PE index ping-pong buffer. Accepts packed index

---
 rtl/pe_idx_loader.sv | 173 +++++++++++++++++
 tb/tb_pe_idx_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_idx_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pe_idx_loader                                                |
// | Description : Write-side front end of the PE index ping-pong buffer.       |
// |               Takes packed index beats over valid/ready, unpacks them into |
// |               {idx_hi, idx_lo} entries one per cycle onto the index write  |
// |               port, then pulses switch_idx_buf once the PE AGU is idle.    |
// | Ports       : clk, rst (sync, active-low)                                  |
// |               load_start/load_cnt/load_done  - per-set load control        |
// |               in_data/in_valid/in_ready      - packed beat input, lane0 LSB|
// |               agu_done                       - read half may be swapped    |
// |               idx_wr_data/addr/en            - registered RAM write port   |
// |               switch_idx_buf                 - one-cycle swap pulse        |
// |               load_err                       - sticky error (optional)     |
// | Config      : IDX_LOAD_ERR_EN defined adds the load_err port               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pe_idx_loader #(
    parameter int IDX_W      = 4,
    parameter int IDX_DEPTH  = 256,
    parameter int IDX_ADDR_W = $clog2(IDX_DEPTH),
    parameter int IN_W       = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [7:0]            load_cnt,
    output logic                  load_done,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  agu_done,
    output logic [2*IDX_W-1:0]    idx_wr_data,
    output logic [IDX_ADDR_W-1:0] idx_wr_addr,
    output logic                  idx_wr_en,
    output logic                  switch_idx_buf
`ifdef IDX_LOAD_ERR_EN
    ,
    output logic                  load_err
`endif
);

    localparam int c_ENT_W  = 2 * IDX_W;
    localparam int c_LANES  = IN_W / c_ENT_W;
    localparam int c_PEND_W = $clog2(c_LANES + 1);

    localparam logic [IDX_ADDR_W-1:0] c_ADDR_MAX = IDX_ADDR_W'(IDX_DEPTH - 1);

    localparam logic [1:0] c_S_IDLE      = 2'd0;
    localparam logic [1:0] c_S_LOAD      = 2'd1;
    localparam logic [1:0] c_S_WAIT_SWAP = 2'd2;
    localparam logic [1:0] c_S_SWAP      = 2'd3;

    logic [1:0]            r_state;
    logic [7:0]            r_cnt;        // latched load_cnt
    logic [7:0]            r_wr_cnt;     // entries issued so far
    logic [IDX_ADDR_W-1:0] r_next_addr;
    logic [IN_W-1:0]       r_buf;        // remaining lanes of current beat, next lane in LSBs
    logic [c_PEND_W-1:0]   r_pend;       // usable lanes still held in r_buf
    logic                  r_load_done;
    logic                  r_wr_en;
    logic [c_ENT_W-1:0]    r_wr_data;
    logic [IDX_ADDR_W-1:0] r_wr_addr;
    logic                  r_switch;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_emit_buf;
    logic                  w_emit;
    logic                  w_last;
    logic [7:0]            w_rem;
    logic [c_PEND_W-1:0]   w_use;

    // A new beat is taken only once the previous one is fully drained; lane 0
    // of the accepted beat goes straight to the write register, so the buffer
    // draining and the next acceptance chain with no bubble.
    assign w_in_ready = (r_state == c_S_LOAD) && (r_pend == '0) && (r_wr_cnt != r_cnt);
    assign w_accept   = w_in_ready && in_valid;
    assign w_emit_buf = (r_state == c_S_LOAD) && (r_pend != '0);
    assign w_emit     = w_emit_buf || w_accept;
    assign w_last     = ((r_wr_cnt + 8'd1) == r_cnt);
    assign w_rem      = r_cnt - r_wr_cnt;
    // Lanes of the beat that belong to this set; the rest are dropped.
    assign w_use      = (32'(w_rem) >= c_LANES) ? c_PEND_W'(c_LANES) : c_PEND_W'(w_rem);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_wr_cnt    <= '0;
            r_next_addr <= '0;
            r_buf       <= '0;
            r_pend      <= '0;
            r_load_done <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_wr_addr   <= '0;
            r_switch    <= 1'b0;
        end else begin
            r_wr_en  <= 1'b0;
            r_switch <= 1'b0;

            if (w_emit) begin
                r_wr_en     <= 1'b1;
                r_wr_addr   <= r_next_addr;
                r_next_addr <= (r_next_addr == c_ADDR_MAX) ? '0 : r_next_addr + 1'b1;
                r_wr_cnt    <= r_wr_cnt + 8'd1;
            end

            if (w_emit_buf) begin
                r_wr_data <= r_buf[c_ENT_W-1:0];
                r_buf     <= r_buf >> c_ENT_W;
                r_pend    <= r_pend - 1'b1;
            end else if (w_accept) begin
                r_wr_data <= in_data[c_ENT_W-1:0];
                r_buf     <= in_data >> c_ENT_W;
                r_pend    <= w_use - 1'b1;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (load_start) begin
                        r_cnt       <= load_cnt;
                        r_wr_cnt    <= '0;
                        r_next_addr <= '0;
                        r_load_done <= 1'b0;
                        r_state     <= (load_cnt == 8'd0) ? c_S_WAIT_SWAP : c_S_LOAD;
                    end
                end
                c_S_LOAD: begin
                    if (w_emit && w_last) begin
                        r_state <= c_S_WAIT_SWAP;
                    end
                end
                c_S_WAIT_SWAP: begin
                    if (agu_done) begin
                        r_state  <= c_S_SWAP;
                        r_switch <= 1'b1;
                    end
                end
                c_S_SWAP: begin
                    r_state     <= c_S_IDLE;
                    r_load_done <= 1'b1;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign load_done      = r_load_done;
    assign in_ready       = w_in_ready;
    assign idx_wr_en      = r_wr_en;
    assign idx_wr_data    = r_wr_data;
    assign idx_wr_addr    = r_wr_addr;
    assign switch_idx_buf = r_switch;

`ifdef IDX_LOAD_ERR_EN
    logic r_err;

    // Sticky: start while busy, or a set larger than one buffer half.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (load_start && ((r_state != c_S_IDLE) || (32'(load_cnt) > IDX_DEPTH))) begin
            r_err <= 1'b1;
        end
    end

    assign load_err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_idx_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pe_idx_loader                                             |
// | Description : Directed self-checking bench for pe_idx_loader               |
// |               (IN_W=64, IDX_W=4, IDX_DEPTH=128).                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pe_idx_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [7:0]  load_cnt;
    logic        load_done;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        agu_done;
    logic [7:0]  idx_wr_data;
    logic [6:0]  idx_wr_addr;
    logic        idx_wr_en;
    logic        switch_idx_buf;
`ifdef IDX_LOAD_ERR_EN
    logic        load_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] beats[$];

    pe_idx_loader #(
        .IDX_W     (4),
        .IDX_DEPTH (128),
        .IDX_ADDR_W(7),
        .IN_W      (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .load_cnt      (load_cnt),
        .load_done     (load_done),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .agu_done      (agu_done),
        .idx_wr_data   (idx_wr_data),
        .idx_wr_addr   (idx_wr_addr),
        .idx_wr_en     (idx_wr_en),
        .switch_idx_buf(switch_idx_buf)
`ifdef IDX_LOAD_ERR_EN
        ,
        .load_err      (load_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entry j of the current stimulus set: lane j%8 of beat j/8.
    function automatic logic [7:0] exp_entry(input int j);
        logic [63:0] b;
        b = beats[j / 8];
        return b[(j % 8) * 8 +: 8];
    endfunction

    // Call from IDLE; returns in the first LOAD cycle.
    task automatic start(input logic [7:0] cnt);
        load_cnt   = cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_done_low", {63'd0, load_done}, 64'd0);
    endtask

    // Feeds beats[] with valid/ready and checks every write until n are seen.
    task automatic stream(input int n, input bit tgl);
        int  got   = 0;
        int  bi    = 0;
        int  cyc   = 0;
        int  first = 0;
        int  last  = 0;
        bit  acc;
        in_data  = beats[0];
        in_valid = 1'b1;
        while (got < n && cyc < 400) begin
            acc = in_valid && in_ready;
            tick();
            load_start = 1'b0;
            cyc++;
            if (acc) begin
                bi++;
                in_data = (bi < beats.size()) ? beats[bi] : 64'hDEAD_BEEF_DEAD_BEEF;
            end
            if (tgl) in_valid = !in_valid;
            if (idx_wr_en) begin
                chk("wr_addr", {57'd0, idx_wr_addr}, 64'(got % 128));
                chk("wr_data", {56'd0, idx_wr_data}, {56'd0, exp_entry(got)});
                if (got == 0) first = cyc;
                last = cyc;
                got++;
            end
        end
        chk("wr_count", 64'(got), 64'(n));
        chk("beats_taken", 64'(bi), 64'((n + 7) / 8));
        chk("ready_after_last", {63'd0, in_ready}, 64'd0);
        if (!tgl) chk("no_gap", 64'(last - first), 64'(n - 1));
        in_valid = 1'b0;
    endtask

    // Call in the WAIT_SWAP cycle with agu_done=1.
    task automatic expect_swap();
        tick();
        chk("switch_pulse", {63'd0, switch_idx_buf}, 64'd1);
        chk("done_in_swap", {63'd0, load_done}, 64'd0);
        tick();
        chk("switch_end", {63'd0, switch_idx_buf}, 64'd0);
        chk("done_after_swap", {63'd0, load_done}, 64'd1);
    endtask

    initial begin
        rst        = 1'b0;
        load_start = 1'b0;
        load_cnt   = 8'd0;
        in_data    = 64'd0;
        in_valid   = 1'b0;
        agu_done   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_load_done", {63'd0, load_done}, 64'd1);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_wr_en", {63'd0, idx_wr_en}, 64'd0);
        chk("rst_wr_addr", {57'd0, idx_wr_addr}, 64'd0);
        chk("rst_wr_data", {56'd0, idx_wr_data}, 64'd0);
        chk("rst_switch", {63'd0, switch_idx_buf}, 64'd0);
`ifdef IDX_LOAD_ERR_EN
        chk("rst_err", {63'd0, load_err}, 64'd0);
`endif
        rst = 1'b1;
        tick();

        // 1: single full beat
        agu_done = 1'b1;
        beats = '{64'h8877_6655_4433_2211};
        start(8'd8);
        chk("t1_ready", {63'd0, in_ready}, 64'd1);
        stream(8, 1'b0);
        expect_swap();

        // 2: partial final beat, lanes 2..7 dropped
        beats = '{64'h1817_1615_1413_1211, 64'h2827_2625_2423_2221, 64'h3333_3333_3333_3333};
        start(8'd10);
        stream(10, 1'b0);
        expect_swap();

        // 3a: back-to-back beats, no bubble
        beats = '{64'h3837_3635_3433_3231, 64'h4847_4645_4443_4241};
        start(8'd16);
        stream(16, 1'b0);
        expect_swap();

        // 3b: in_valid toggling every cycle
        beats = '{64'h5857_5655_5453_5251, 64'h6867_6665_6463_6261};
        start(8'd16);
        stream(16, 1'b1);
        expect_swap();

        // 4: AGU busy holds the swap; load_start while waiting is ignored
        agu_done = 1'b0;
        beats = '{64'hA8A7_A6A5_A4A3_A2A1};
        start(8'd8);
        stream(8, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            load_start = (i == 5);
            load_cnt   = 8'd3;
            tick();
            chk("t4_no_switch", {63'd0, switch_idx_buf}, 64'd0);
            chk("t4_no_ready", {63'd0, in_ready}, 64'd0);
            chk("t4_no_write", {63'd0, idx_wr_en}, 64'd0);
            chk("t4_busy", {63'd0, load_done}, 64'd0);
        end
        load_start = 1'b0;
        in_valid   = 1'b0;
        agu_done   = 1'b1;
        expect_swap();
        tick();
        chk("t4_idle_no_switch", {63'd0, switch_idx_buf}, 64'd0);
`ifdef IDX_LOAD_ERR_EN
        chk("t4_err_set", {63'd0, load_err}, 64'd1);
`endif

        // 5: reset in the middle of a 12-entry load
        beats = '{64'h7877_7675_7473_7271};
        start(8'd12);
        in_data  = beats[0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t5_third_wr_en", {63'd0, idx_wr_en}, 64'd1);
        chk("t5_third_addr", {57'd0, idx_wr_addr}, 64'd2);
        chk("t5_third_data", {56'd0, idx_wr_data}, 64'h73);
        rst = 1'b0;
        tick();
        chk("t5_rst_wr_en", {63'd0, idx_wr_en}, 64'd0);
        chk("t5_rst_done", {63'd0, load_done}, 64'd1);
        chk("t5_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("t5_rst_addr", {57'd0, idx_wr_addr}, 64'd0);
`ifdef IDX_LOAD_ERR_EN
        chk("t5_err_cleared", {63'd0, load_err}, 64'd0);
`endif
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_no_switch", {63'd0, switch_idx_buf}, 64'd0);
        end
        beats = '{64'hA5A5_A5A5_9493_9291};
        start(8'd4);
        stream(4, 1'b0);
        expect_swap();
`ifdef IDX_LOAD_ERR_EN
        chk("t5_err_clean", {63'd0, load_err}, 64'd0);
`endif

        // 6: 130 entries into a 128-deep half; load_start mid-load ignored
        beats.delete();
        for (int b = 0; b < 17; b++) begin
            logic [63:0] w;
            for (int l = 0; l < 8; l++) w[l*8 +: 8] = 8'(b * 8 + l);
            beats.push_back(w);
        end
        start(8'd130);
        load_cnt   = 8'd5;
        load_start = 1'b1;
        stream(130, 1'b0);
        expect_swap();
`ifdef IDX_LOAD_ERR_EN
        chk("t6_err_sticky", {63'd0, load_err}, 64'd1);
        rst = 1'b0;
        tick();
        chk("t6_err_rst", {63'd0, load_err}, 64'd0);
        rst = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
